// File: rtl/intnorm_pipe_shift_if.sv
// Handshake bundle for intnorm_pipe_shift: operand side (in_*) and result side (out_*).
interface intnorm_pipe_shift_if #(
  parameter int WIDTH  = 68,
  parameter int TAGW   = 4,
  parameter int SHAMTW = $clog2(WIDTH) + 1
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_mode;
  logic [SHAMTW-1:0] in_shamt;
  logic [WIDTH-1:0]  in_data;
  logic [TAGW-1:0]   in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [SHAMTW-1:0] out_count;
  logic              out_zero;
  logic              out_sticky;
  logic [TAGW-1:0]   out_tag;

  modport master (
    output in_valid, in_mode, in_shamt, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_zero, out_sticky, out_tag
  );

  modport slave (
    input  in_valid, in_mode, in_shamt, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_count, out_zero, out_sticky, out_tag
  );
endinterface

// File: rtl/intnorm_pipe_shift.sv
// Pipelined SLL/SRL/SRA/NORM shifter; shift-amount bits are consumed LSB group first, one group per stage.
// Define INTNORM_STICKY_EN to build the per-stage sticky accumulation for right shifts.
module intnorm_pipe_shift #(
  parameter int WIDTH  = 68,
  parameter int STAGES = 2,
  parameter int TAGW   = 4,
  parameter int SHAMTW = $clog2(WIDTH) + 1
) (
  input logic                 clk,
  input logic                 reset_n,
  intnorm_pipe_shift_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_SLL  = 2'b00,
    MODE_SRL  = 2'b01,
    MODE_SRA  = 2'b10,
    MODE_NORM = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] ONES = '1;

  // Even split of amount bits; STAGES <= SHAMTW keeps every group non-empty.
  function automatic logic [SHAMTW-1:0] grp_mask(input int k);
    logic [SHAMTW-1:0] m;
    int lo;
    int hi;
    lo = (k * SHAMTW) / STAGES;
    hi = ((k + 1) * SHAMTW) / STAGES;
    m  = '0;
    for (int b = 0; b < SHAMTW; b++) begin
      if (b >= lo && b < hi) m[b] = 1'b1;
    end
    return m;
  endfunction

  logic              stall;
  logic [SHAMTW-1:0] lzc;
  logic              lz_found;
  logic [SHAMTW-1:0] fe_amt;

  logic              valid_q  [0:STAGES-1];
  logic              valid_d  [0:STAGES-1];
  logic [WIDTH-1:0]  data_q   [0:STAGES-1];
  logic [WIDTH-1:0]  data_d   [0:STAGES-1];
  logic [SHAMTW-1:0] rem_q    [0:STAGES-1];
  logic [SHAMTW-1:0] rem_d    [0:STAGES-1];
  logic [SHAMTW-1:0] count_q  [0:STAGES-1];
  logic [SHAMTW-1:0] count_d  [0:STAGES-1];
  mode_e             mode_q   [0:STAGES-1];
  mode_e             mode_d   [0:STAGES-1];
  logic [TAGW-1:0]   tag_q    [0:STAGES-1];
  logic [TAGW-1:0]   tag_d    [0:STAGES-1];
  logic              zero_q;
  logic              zero_d;

  logic              src_valid [0:STAGES-1];
  logic [WIDTH-1:0]  src_data  [0:STAGES-1];
  logic [SHAMTW-1:0] src_rem   [0:STAGES-1];
  logic [SHAMTW-1:0] src_count [0:STAGES-1];
  mode_e             src_mode  [0:STAGES-1];
  logic [TAGW-1:0]   src_tag   [0:STAGES-1];
  logic [SHAMTW-1:0] sh        [0:STAGES-1];

`ifdef INTNORM_STICKY_EN
  logic              sticky_q   [0:STAGES-1];
  logic              sticky_d   [0:STAGES-1];
  logic              src_sticky [0:STAGES-1];
`endif

  assign stall        = valid_q[STAGES-1] & ~bus.out_ready;
  assign bus.in_ready = ~stall;

  // Front end: leading-zero count; an all-zero operand yields WIDTH.
  always_comb begin
    lzc      = SHAMTW'(WIDTH);
    lz_found = 1'b0;
    for (int b = WIDTH - 1; b >= 0; b--) begin
      if (!lz_found && bus.in_data[b]) begin
        lzc      = SHAMTW'(WIDTH - 1 - b);
        lz_found = 1'b1;
      end
    end
  end

  always_comb begin
    if (mode_e'(bus.in_mode) == MODE_NORM) begin
      fe_amt = lzc;
    end else if (bus.in_shamt > SHAMTW'(WIDTH)) begin
      fe_amt = SHAMTW'(WIDTH);
    end else begin
      fe_amt = bus.in_shamt;
    end
  end

  always_comb begin
    src_valid = '{default: 1'b0};
    src_data  = '{default: '0};
    src_rem   = '{default: '0};
    src_count = '{default: '0};
    src_mode  = '{default: MODE_SLL};
    src_tag   = '{default: '0};
    sh        = '{default: '0};
    valid_d   = '{default: 1'b0};
    data_d    = '{default: '0};
    rem_d     = '{default: '0};
    count_d   = '{default: '0};
    mode_d    = '{default: MODE_SLL};
    tag_d     = '{default: '0};
`ifdef INTNORM_STICKY_EN
    src_sticky = '{default: 1'b0};
    sticky_d   = '{default: 1'b0};
`endif

    src_valid[0] = bus.in_valid;
    src_data[0]  = bus.in_data;
    src_rem[0]   = fe_amt;
    src_count[0] = fe_amt;
    src_mode[0]  = mode_e'(bus.in_mode);
    src_tag[0]   = bus.in_tag;
    for (int k = 1; k < STAGES; k++) begin
      src_valid[k] = valid_q[k-1];
      src_data[k]  = data_q[k-1];
      src_rem[k]   = rem_q[k-1];
      src_count[k] = count_q[k-1];
      src_mode[k]  = mode_q[k-1];
      src_tag[k]   = tag_q[k-1];
`ifdef INTNORM_STICKY_EN
      src_sticky[k] = sticky_q[k-1];
`endif
    end

    // Each stage shifts by its own group's weighted bits; the total never exceeds WIDTH.
    for (int k = 0; k < STAGES; k++) begin
      sh[k]      = src_rem[k] & grp_mask(k);
      rem_d[k]   = src_rem[k] & ~grp_mask(k);
      valid_d[k] = src_valid[k];
      count_d[k] = src_count[k];
      mode_d[k]  = src_mode[k];
      tag_d[k]   = src_tag[k];
      case (src_mode[k])
        MODE_SRL: data_d[k] = src_data[k] >> sh[k];
        MODE_SRA: data_d[k] = $signed(src_data[k]) >>> sh[k];
        default:  data_d[k] = src_data[k] << sh[k];
      endcase
`ifdef INTNORM_STICKY_EN
      if (src_mode[k] == MODE_SRL || src_mode[k] == MODE_SRA) begin
        sticky_d[k] = src_sticky[k] | (|(src_data[k] & ~(ONES << sh[k])));
      end else begin
        sticky_d[k] = 1'b0;
      end
`endif
    end

    zero_d = ~|data_d[STAGES-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        data_q[k]  <= '0;
        rem_q[k]   <= '0;
        count_q[k] <= '0;
        mode_q[k]  <= MODE_SLL;
        tag_q[k]   <= '0;
`ifdef INTNORM_STICKY_EN
        sticky_q[k] <= 1'b0;
`endif
      end
      zero_q <= 1'b0;
    end else if (!stall) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        data_q[k]  <= data_d[k];
        rem_q[k]   <= rem_d[k];
        count_q[k] <= count_d[k];
        mode_q[k]  <= mode_d[k];
        tag_q[k]   <= tag_d[k];
`ifdef INTNORM_STICKY_EN
        sticky_q[k] <= sticky_d[k];
`endif
      end
      zero_q <= zero_d;
    end
  end

  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.out_data  = data_q[STAGES-1];
  assign bus.out_count = count_q[STAGES-1];
  assign bus.out_zero  = zero_q;
  assign bus.out_tag   = tag_q[STAGES-1];
`ifdef INTNORM_STICKY_EN
  assign bus.out_sticky = sticky_q[STAGES-1];
`else
  assign bus.out_sticky = 1'b0;
`endif

endmodule

// File: doc/intnorm_pipe_shift.md
# intnorm_pipe_shift

Pipelined, parametrised successor to the integer normalization shifter used by the divide/sqrt integer post-processing path. It accepts a WIDTH-bit operand with a valid/ready handshake, performs one of four shift modes (logical left, logical right, arithmetic right, auto-normalize by leading-zero count) split across STAGES registered stages, and returns the result with the applied shift count, zero flag and an optional sticky bit. It sits between the fdivsqrt iteration core and the integer result mux, replacing the single-cycle combinational shift when timing requires it.

## Interface
- WIDTH, 68, operand/result width (DIVb+4 for DIVb=64); minimum 4.
- STAGES, 2, registered pipeline stages, 1..SHAMTW-1.
- TAGW, 4, width of the sideband tag carried with each operation.
- SHAMTW, $clog2(WIDTH)+1, shift-amount width (derived; must represent WIDTH).
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  pipeline can accept this cycle.
- in_mode  in  2  00 SLL, 01 SRL, 10 SRA, 11 NORM.
- in_shamt  in  SHAMTW  shift amount; ignored in NORM.
- in_data  in  WIDTH  operand (signed for SRA).
- in_tag  in  TAGW  passed through unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  shifted result.
- out_count  out  SHAMTW  shift amount actually applied (LZC in NORM, saturated in_shamt otherwise).
- out_zero  out  1  out_data == 0.
- out_sticky  out  1  OR of bits shifted out on right shifts (0 when INTNORM_STICKY_EN undefined).
- out_tag  out  TAGW  tag of the result.

## Operation
- Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
- stall = out_valid & ~out_ready; in_ready = ~stall. While stalled, every stage register holds; no bubble collapsing. When not stalled, all stages advance together; a stage with no valid data advances as a bubble.
- Stage 0 (combinational front end): NORM computes leading-zero count of in_data; zero operand gives count WIDTH. Effective amount = min(in_shamt or LZC, WIDTH).
- Shift amount bits are split into STAGES contiguous groups, LSB group first; stage k applies its group's shift and registers partial result, remaining amount, mode, tag, valid, sticky.
- SLL/NORM fill zeros from right; SRL fills zeros from left; SRA fills copies of in_data[WIDTH-1].
- Amount == WIDTH: SLL/SRL/NORM give 0; SRA gives all sign bits.
- NORM result has out_data[WIDTH-1]=1 unless operand is zero (then out_data=0, out_zero=1, out_count=WIDTH).
- out_sticky = OR of all bits discarded by SRL/SRA; 0 for SLL/NORM.
- Reset values: all stage valids 0, out_valid 0, out_data 0, out_count 0, out_zero 0, out_sticky 0, out_tag 0. in_ready is 1 out of reset.

## Timing
- Latency: exactly STAGES cycles from input transfer to out_valid when unstalled.
- Throughput: one operation per cycle with out_ready held high.
- out_* stable while out_valid & ~out_ready.
- Simultaneous output and input transfer in same cycle is legal and is the steady-state case.
- reset_n asserted mid-operation: all in-flight operations discarded immediately (asynchronous); no output appears for them after release.
- in_ready depends combinationally on out_ready (no skid buffer); consumers must not make out_ready depend on in_valid.

## Configuration
- INTNORM_STICKY_EN defined: sticky accumulation logic per stage included; out_sticky as specified.
- Undefined: no sticky logic synthesised; out_sticky tied to 0.

## Test plan
- WIDTH=16, STAGES=2: NORM in_data=16'h0013 -> after 2 cycles out_data=16'h9800, out_count=11, out_zero=0.
- NORM in_data=16'h0000 -> out_data=0, out_count=16, out_zero=1.
- SRA in_data=16'h8001, in_shamt=4 -> out_data=16'hF800, out_count=4, out_sticky=1 (with INTNORM_STICKY_EN), 0 without.
- SRL in_shamt=16 on 16'hFFFF -> out_data=0, out_count=16, out_sticky=1; SLL shamt=3 on 16'h1234 -> 16'h91A0, out_sticky=0.
- Back-to-back 8 operations with tags 0..7, out_ready low for 3 cycles mid-stream -> in_ready low those cycles, outputs held stable, all 8 results in order with matching tags, none lost or duplicated.
- Pulse reset_n low while 2 operations in flight -> out_valid=0 and all outputs 0 immediately; no stale results after release; in_ready=1.
